// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared constants and types for the TPU operand feeder.
//               DATA_WIDTH - element width in bits
//               ARRAY_N    - PE grid dimension (lanes per operand bus)
//               STREAM_LEN - stream cycles per run, including the drain tail
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ARRAY_N    = 4;
  // ARRAY_N skewed input cycles, ARRAY_N-1 extra for the skew itself,
  // plus drain so the last product lands in the far corner PE.
  localparam int STREAM_LEN = 2 * ARRAY_N + 2;

  localparam int T_WIDTH    = 4;
  localparam int IDX_WIDTH  = $clog2(ARRAY_N);
  localparam int BUS_WIDTH  = DATA_WIDTH * ARRAY_N;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_e;

  typedef logic [DATA_WIDTH-1:0] elem_t;

endpackage
`default_nettype wire

// File: rtl/skew_lane.sv
`default_nettype none
// ============================================================================
// Module      : skew_lane
// Description : Per-lane skew select. For stream cycle t and lane index L it
//               returns element (t - L) of the supplied vector when that
//               offset lies in 0..ARRAY_N-1, otherwise zero.
// Ports       : lane_idx - lane number of this instance
//               t        - current stream cycle
//               vec      - ARRAY_N packed elements, element e at [8e+7:8e]
//               elem     - selected element, or zero outside the window
// Revision    : 1.0 - initial release
// ============================================================================
module skew_lane
  import tpu_pkg::*;
(
  input  logic [IDX_WIDTH-1:0] lane_idx,
  input  logic [T_WIDTH-1:0]   t,
  input  logic [BUS_WIDTH-1:0] vec,
  output logic [DATA_WIDTH-1:0] elem
);

  logic [T_WIDTH:0]   w_diff;
  logic               w_in_range;
  logic [IDX_WIDTH-1:0] w_sel;

  always_comb begin
    w_diff     = {1'b0, t} - (T_WIDTH + 1)'(lane_idx);
    // Extra MSB keeps the subtraction from wrapping when t < lane_idx.
    w_in_range = (t >= T_WIDTH'(lane_idx)) &&
                 (w_diff < (T_WIDTH + 1)'(ARRAY_N));
    w_sel      = w_diff[IDX_WIDTH-1:0];
    elem       = '0;
    if (w_in_range) begin
      elem = vec[w_sel * DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Holds a 4x4 A bank and a 4x4 B bank and streams them into a
//               systolic PE grid with row skew on A and column skew on B.
// Ports       : clk, rst_n          - clock, async active-low reset
//               load_valid/ready    - row load handshake (ready only in IDLE)
//               load_sel            - 0 = A row, 1 = B row
//               load_addr/load_data - row index and packed row elements
//               start               - launch a stream run (IDLE only)
//               busy                - STREAM or DONE
//               done                - one-cycle pulse after the last stream cycle
//               a_in, b_in          - skewed lane buses, lane n at [8n+7:8n]
//               we                  - PE grid enable, high in STREAM only
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder
  import tpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic                 load_sel,
  input  logic [IDX_WIDTH-1:0] load_addr,
  input  logic [BUS_WIDTH-1:0] load_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] a_in,
  output logic [BUS_WIDTH-1:0] b_in,
  output logic                 we
);

  localparam logic [T_WIDTH-1:0] c_LAST_T = T_WIDTH'(STREAM_LEN - 1);

  feeder_state_e r_state;
  feeder_state_e w_state_next;
  logic [T_WIDTH-1:0] r_t;

  elem_t r_bank_a [ARRAY_N][ARRAY_N];
  elem_t r_bank_b [ARRAY_N][ARRAY_N];

  logic w_idle;
  logic w_stream;
  logic w_done;
  logic w_load_fire;

  logic [ARRAY_N-1:0][BUS_WIDTH-1:0]  w_a_row;
  logic [ARRAY_N-1:0][BUS_WIDTH-1:0]  w_b_col;
  logic [ARRAY_N-1:0][DATA_WIDTH-1:0] w_a_lane;
  logic [ARRAY_N-1:0][DATA_WIDTH-1:0] w_b_lane;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state decodes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_idle       = 1'b0;
    w_stream     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        if (start) begin
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_stream = 1'b1;
        if (r_t == c_LAST_T) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // load_ready is gated with rst_n so it reads low for the whole reset window,
  // even though the state register already sits at IDLE.
  assign load_ready  = w_idle & rst_n;
  assign w_load_fire = load_valid & load_ready;
  assign busy        = w_stream | w_done;
  assign done        = w_done;
  assign we          = w_stream;

  // --------------------------------------------------------------------------
  // Stream cycle counter: held at 0 outside STREAM so the first stream cycle
  // always presents t=0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t <= '0;
    end else if (w_stream && (r_t != c_LAST_T)) begin
      r_t <= r_t + 1'b1;
    end else begin
      r_t <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Operand banks. A row write accepted on the same edge as start is already
  // in the bank when t=0 is presented.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARRAY_N; i++) begin
        for (int e = 0; e < ARRAY_N; e++) begin
          r_bank_a[i][e] <= '0;
          r_bank_b[i][e] <= '0;
        end
      end
    end else if (w_load_fire) begin
      for (int e = 0; e < ARRAY_N; e++) begin
        if (load_sel) begin
          r_bank_b[load_addr][e] <= load_data[e * DATA_WIDTH +: DATA_WIDTH];
        end else begin
          r_bank_a[load_addr][e] <= load_data[e * DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // A lane i walks along row i; B lane j walks down column j.
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_row = '0;
    w_b_col = '0;
    for (int n = 0; n < ARRAY_N; n++) begin
      for (int e = 0; e < ARRAY_N; e++) begin
        w_a_row[n][e * DATA_WIDTH +: DATA_WIDTH] = r_bank_a[n][e];
        w_b_col[n][e * DATA_WIDTH +: DATA_WIDTH] = r_bank_b[e][n];
      end
    end
  end

  generate
    for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
      skew_lane u_skew_a (
        .lane_idx (IDX_WIDTH'(n)),
        .t        (r_t),
        .vec      (w_a_row[n]),
        .elem     (w_a_lane[n])
      );
      skew_lane u_skew_b (
        .lane_idx (IDX_WIDTH'(n)),
        .t        (r_t),
        .vec      (w_b_col[n]),
        .elem     (w_b_lane[n])
      );
    end
  endgenerate

  // Buses are forced to zero outside STREAM; t rests at 0 in IDLE and would
  // otherwise expose element 0 of lane 0.
  assign a_in = w_stream ? w_a_lane : '0;
  assign b_in = w_stream ? w_b_lane : '0;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feeder
// Description : Directed, table-driven bench for systolic_feeder. Captures
//               each stream run and compares it against hand-computed lane
//               values, plus sequences for reset, handshake and restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic        load_sel;
  logic [1:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        we;

  systolic_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_sel   (load_sel),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .a_in       (a_in),
    .b_in       (b_in),
    .we         (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          run;
    int          t;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] cap_a [4][10];
  logic [31:0] cap_b [4][10];
  int          n_tests;
  int          n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; one load beat.
  task automatic load_row(input logic sel, input logic [1:0] addr, input logic [31:0] data);
    load_valid = 1'b1;
    load_sel   = sel;
    load_addr  = addr;
    load_data  = data;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Called at a falling edge. Captures the run into cap_*[r].
  task automatic run_stream(input int r, input bit ld_en, input logic [31:0] ld_data,
                            input bit hold_ld, input bit restart);
    int n_we;
    int n_done;
    int done_idx;
    int bad_ready;
    start = 1'b1;
    if (ld_en) begin
      load_valid = 1'b1;
      load_sel   = 1'b0;
      load_addr  = 2'd0;
      load_data  = ld_data;
    end
    @(negedge clk);
    start      = 1'b0;
    load_valid = 1'b0;
    if (hold_ld) begin
      load_valid = 1'b1;
      load_sel   = 1'b0;
      load_addr  = 2'd1;
      load_data  = 32'hA5A5_A5A5;
    end
    n_we = 0; n_done = 0; done_idx = -1; bad_ready = 0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (we && c < 10) begin
        cap_a[r][c] = a_in;
        cap_b[r][c] = b_in;
      end
      if (we) n_we++;
      if (busy && load_ready) bad_ready++;
      if (done) begin
        n_done++;
        done_idx = c;
      end
      start = restart && (c == 4);
      if (c >= 10) load_valid = 1'b0;
    end
    start      = 1'b0;
    load_valid = 1'b0;
    chk($sformatf("run%0d_we_cycles", r), n_we, 10);
    chk($sformatf("run%0d_done_count", r), n_done, 1);
    chk($sformatf("run%0d_done_cycle", r), done_idx, 10);
    chk($sformatf("run%0d_ready_while_busy", r), bad_ready, 0);
  endtask

  task automatic apply_table(input int r);
    foreach (tbl[k]) begin
      if (tbl[k].run == r) begin
        chk($sformatf("run%0d_t%0d_a_in", r, tbl[k].t), cap_a[r][tbl[k].t], tbl[k].a);
        chk($sformatf("run%0d_t%0d_b_in", r, tbl[k].t), cap_b[r][tbl[k].t], tbl[k].b);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    n_tests = 0;
    n_fail  = 0;
    for (int r = 0; r < 4; r++)
      for (int t = 0; t < 10; t++) begin
        cap_a[r][t] = '0;
        cap_b[r][t] = '0;
      end

    // Run 0: A = I, B[k][j] = 4k+j+1
    tbl.push_back('{0, 0, 32'h0000_0001, 32'h0000_0001});
    tbl.push_back('{0, 1, 32'h0000_0000, 32'h0000_0205});
    tbl.push_back('{0, 2, 32'h0000_0100, 32'h0003_0609});
    tbl.push_back('{0, 3, 32'h0000_0000, 32'h0407_0a0d});
    tbl.push_back('{0, 4, 32'h0001_0000, 32'h080b_0e00});
    tbl.push_back('{0, 5, 32'h0000_0000, 32'h0c0f_0000});
    tbl.push_back('{0, 6, 32'h0100_0000, 32'h1000_0000});
    tbl.push_back('{0, 7, 32'h0000_0000, 32'h0000_0000});
    tbl.push_back('{0, 8, 32'h0000_0000, 32'h0000_0000});
    tbl.push_back('{0, 9, 32'h0000_0000, 32'h0000_0000});
    // Run 1: A[i][k] = 16i+k, B unchanged
    tbl.push_back('{1, 0, 32'h0000_0000, 32'h0000_0001});
    tbl.push_back('{1, 1, 32'h0000_1001, 32'h0000_0205});
    tbl.push_back('{1, 3, 32'h3021_1203, 32'h0407_0a0d});
    tbl.push_back('{1, 6, 32'h3300_0000, 32'h1000_0000});
    tbl.push_back('{1, 8, 32'h0000_0000, 32'h0000_0000});
    // Run 3: after reset, A row0 = {9,9,9,9} loaded with start
    tbl.push_back('{3, 0, 32'h0000_0009, 32'h0000_0000});
    tbl.push_back('{3, 1, 32'h0000_0009, 32'h0000_0000});
    tbl.push_back('{3, 3, 32'h0000_0009, 32'h0000_0000});
    tbl.push_back('{3, 4, 32'h0000_0000, 32'h0000_0000});

    load_valid = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_we", we, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", load_ready, 0);
    chk("reset_a_in", a_in, 0);
    chk("reset_b_in", b_in, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", load_ready, 1);

    // Identity A, ramp B
    for (int i = 0; i < 4; i++) load_row(1'b0, 2'(i), 32'h1 << (8 * i));
    load_row(1'b1, 2'd0, 32'h0403_0201);
    load_row(1'b1, 2'd1, 32'h0807_0605);
    load_row(1'b1, 2'd2, 32'h0c0b_0a09);
    load_row(1'b1, 2'd3, 32'h100f_0e0d);
    run_stream(0, 1'b0, 32'h0, 1'b0, 1'b0);
    apply_table(0);

    // Output-stationary grid model: PE(i,j) sees lane i of a delayed by j
    // and lane j of b delayed by i. With A = I the result must equal B.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int t = 0; t < 10; t++)
          if (t >= i && t >= j)
            acc += int'(cap_a[0][t-j][8*i +: 8]) * int'(cap_b[0][t-i][8*j +: 8]);
        chk($sformatf("grid_c%0d%0d", i, j), acc, 4 * i + j + 1);
      end

    // Skew pattern, with a conflicting load held for the whole stream
    load_row(1'b0, 2'd0, 32'h0302_0100);
    load_row(1'b0, 2'd1, 32'h1312_1110);
    load_row(1'b0, 2'd2, 32'h2322_2120);
    load_row(1'b0, 2'd3, 32'h3332_3130);
    run_stream(1, 1'b0, 32'h0, 1'b1, 1'b0);
    apply_table(1);

    // Replay with a start pulse at t=4; must match run 1 exactly
    run_stream(2, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int t = 0; t < 10; t++) begin
      chk($sformatf("replay_t%0d_a_in", t), cap_a[2][t], cap_a[1][t]);
      chk($sformatf("replay_t%0d_b_in", t), cap_b[2][t], cap_b[1][t]);
    end

    // Reset at t=5
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_we", we, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", we, 0);
    chk("abort_a_in", a_in, 0);
    chk("abort_b_in", b_in, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", load_ready, 0);
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) acc++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready_first_edge", load_ready, 1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) acc++;
    end
    chk("abort_no_done", acc, 0);

    // Same-edge load and start; cleared banks leave only row0 visible
    run_stream(3, 1'b1, 32'h0909_0909, 1'b0, 1'b0);
    apply_table(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 load_valid  input  1  load request for one 4-element vector this cycle.
REQ-004 load_ready  output  1  feeder accepts loads; high only in IDLE.
REQ-005 load_sel  input  1  0 = write A row, 1 = write B row.
REQ-006 load_addr  input  2  A: row i; B: row k.
REQ-007 load_data  input  32  element e at bits [8e+7:8e]; A: A[i][e]; B: B[k][e].
REQ-008 start  input  1  begin streaming the stored A and B.
REQ-009 busy  output  1  high in STREAM and DONE.
REQ-010 done  output  1  one-cycle pulse after the final stream cycle.
REQ-011 a_in  output  32  row-skewed activations; lane i at bits [8i+7:8i].
REQ-012 b_in  output  32  column-skewed weights; lane j at bits [8j+7:8j].
REQ-013 we  output  1  PE-grid enable; high in every STREAM cycle only.

Function
REQ-014 Storage SHALL be two 4x4 banks of 8-bit registers, A and B.
REQ-015 A load SHALL occur on an edge where load_valid && load_ready; it writes bank load_sel, row load_addr. Loads while load_ready is low SHALL be dropped.
REQ-016 States SHALL be IDLE, STREAM, DONE. IDLE->STREAM on start. STREAM->DONE after stream cycle t=9. DONE->IDLE after one cycle.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 A 4-bit counter t SHALL be 0 in the first STREAM cycle and SHALL increment each cycle to 9.
REQ-019 In STREAM cycle t, lane i of a_in SHALL equal A[i][t-i] when 0<=t-i<=3; otherwise it SHALL be 0.
REQ-020 In STREAM cycle t, lane j of b_in SHALL equal B[t-j][j] when 0<=t-j<=3; otherwise it SHALL be 0.
REQ-021 Cycles t=7..9 are drain cycles: all lanes 0, we=1. These cycles let A[3][3] reach PE(3,3).
REQ-022 Outside STREAM, a_in and b_in SHALL be 0 and we SHALL be 0.
REQ-023 Latency: start sampled at edge N; t=0 SHALL be presented during the cycle following edge N; done SHALL be high in the cycle following edge N+10.
REQ-024 When load and start are accepted on the same edge, the written row SHALL be visible from t=0.
REQ-025 Bank contents SHALL persist across runs; a second start with no new loads SHALL replay identical streams.
REQ-026 The feeder SHALL NOT clear PE accumulators. Accumulator clearing is handled by the grid reset.

Reset
REQ-027 While rst_n=0: state=IDLE, t=0, both banks all-zero, a_in=0, b_in=0, we=0, busy=0, done=0, load_ready=0.
REQ-028 When rst_n asserts mid-STREAM, the stream SHALL abort immediately and we SHALL drop asynchronously; no done pulse SHALL follow.
REQ-029 After deassertion, load_ready SHALL be 1 from the first clock edge.

Structure
REQ-030 Shared package tpu_pkg SHALL hold DATA_WIDTH=8, ARRAY_N=4, STREAM_LEN=10 (2*ARRAY_N+2) and the feeder state enum.
REQ-031 The per-lane skew select SHALL be one sub-module, skew_lane. It is instantiated 4x for A and 4x for B, and takes lane index, t, and a 4-element column/row as inputs.
REQ-032 Lane widths SHALL derive from package constants, not from literals.

Verification
REQ-033 Identity load. A=I, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, then start. Required: 10 we cycles. Cycle t=0: a_in=0x00000001, b_in lane0=1, other lanes 0. Grid result = B.
REQ-034 Skew check. A[i][k]=16*i+k, start. Required: at t=3, a_in lanes = {0x03,0x12,0x21,0x30}; at t=6, lane3=0x33 and lanes0-2=0.
REQ-035 Handshake. load_valid held during STREAM with a different value. Required: load_ready=0, bank unchanged, and a replay matches the first run.
REQ-036 Start during busy. start pulsed at t=4. Required: no restart, and done occurs exactly once, 10 cycles after the original start.
REQ-037 Reset mid-stream. rst_n low at t=5. Required: we=0, outputs 0 and banks 0 immediately, no done pulse, and load_ready=1 after release.
REQ-038 Same-edge load and start. Write A row0={9,9,9,9} with start on the same edge. Required: a_in lane0=9 at t=0.
